// File: rtl/trd_sched_if.sv
// Fetch-thread scheduler interface.
// Bundles run mask, miss reports, stall and the grant outputs.
interface trd_sched_if;
  logic [7:0]  run_trd;
  logic        stall;
  logic        i_miss;
  logic [2:0]  i_miss_trd;
  logic        d_miss;
  logic [2:0]  d_miss_trd;
  logic [2:0]  trd_if;
  logic        trd_vld;
  logic [7:0]  blocked;
  logic        idle;
  logic [2:0]  stat_sel;
  logic [15:0] stat_cnt;

  modport master (
    output run_trd, stall,
    output i_miss, i_miss_trd,
    output d_miss, d_miss_trd,
    output stat_sel,
    input  trd_if, trd_vld,
    input  blocked, idle,
    input  stat_cnt
  );

  modport slave (
    input  run_trd, stall,
    input  i_miss, i_miss_trd,
    input  d_miss, d_miss_trd,
    input  stat_sel,
    output trd_if, trd_vld,
    output blocked, idle,
    output stat_cnt
  );
endinterface

// File: rtl/trd_sched.sv
// Round-robin fetch-thread scheduler with per-thread miss back-off.
// TRD_SCHED_STAT_EN adds saturating per-thread issue counters.
module trd_sched #(
  parameter int NUM_TRD   = 8,
  parameter int MISS_WAIT = 4,
  parameter int CNT_W     = 4
) (
  input logic        clk,
  input logic        rst_n,
  trd_sched_if.slave bus
);

  // Counter holds remaining blocked cycles; the miss cycle is the first.
  localparam logic [CNT_W-1:0] LOAD =
    (MISS_WAIT > 0) ? CNT_W'(MISS_WAIT - 1) : '0;

  logic [NUM_TRD-1:0] miss_now;
  logic [NUM_TRD-1:0] elig;
  logic [NUM_TRD-1:0] blocked_q;
  logic [NUM_TRD-1:0] blocked_d;
  logic [CNT_W-1:0]   cnt_q [NUM_TRD];
  logic [CNT_W-1:0]   cnt_d [NUM_TRD];

  logic [2:0] trd_if_q;
  logic [2:0] trd_if_d;
  logic       trd_vld_q;
  logic       trd_vld_d;
  logic [2:0] ptr_q;
  logic [2:0] ptr_d;
  logic [2:0] gnt;
  logic [2:0] idx;
  logic       found;

  always_comb begin
    miss_now = '0;
    elig     = '0;
    for (int t = 0; t < NUM_TRD; t++) begin
      miss_now[t] =
        (bus.i_miss && bus.i_miss_trd == 3'(t)) ||
        (bus.d_miss && bus.d_miss_trd == 3'(t));
      elig[t] = bus.run_trd[t] & ~blocked_q[t]
              & ~miss_now[t];
    end
  end

  // Scan ptr+1 .. ptr+NUM_TRD; the last step lands on ptr itself.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_TRD; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    trd_if_d  = trd_if_q;
    trd_vld_d = trd_vld_q;
    ptr_d     = ptr_q;
    if (!bus.stall) begin
      trd_vld_d = found;
      if (found) begin
        trd_if_d = gnt;
        ptr_d    = gnt;
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_TRD; t++) begin
      cnt_d[t] = cnt_q[t];
      if (!bus.run_trd[t]) begin
        cnt_d[t] = '0;
      end else if (miss_now[t]) begin
        cnt_d[t] = LOAD;
      end else if (cnt_q[t] != '0) begin
        cnt_d[t] = cnt_q[t] - 1'b1;
      end
      blocked_d[t] = |cnt_d[t];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trd_if_q  <= '0;
      trd_vld_q <= 1'b0;
      ptr_q     <= 3'd7;
      blocked_q <= '0;
      for (int t = 0; t < NUM_TRD; t++) begin
        cnt_q[t] <= '0;
      end
    end else begin
      trd_if_q  <= trd_if_d;
      trd_vld_q <= trd_vld_d;
      ptr_q     <= ptr_d;
      blocked_q <= blocked_d;
      for (int t = 0; t < NUM_TRD; t++) begin
        cnt_q[t] <= cnt_d[t];
      end
    end
  end

  assign bus.trd_if  = trd_if_q;
  assign bus.trd_vld = trd_vld_q;
  assign bus.blocked = blocked_q;
  assign bus.idle    = ~|elig;

`ifdef TRD_SCHED_STAT_EN
  logic [15:0] stat_q [NUM_TRD];
  logic [15:0] stat_d [NUM_TRD];

  always_comb begin
    for (int t = 0; t < NUM_TRD; t++) begin
      stat_d[t] = stat_q[t];
      if (trd_vld_q && !bus.stall &&
          trd_if_q == 3'(t) &&
          stat_q[t] != 16'hFFFF) begin
        stat_d[t] = stat_q[t] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TRD; t++) begin
        stat_q[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_TRD; t++) begin
        stat_q[t] <= stat_d[t];
      end
    end
  end

  assign bus.stat_cnt = stat_q[bus.stat_sel];
`else
  logic unused_stat;
  assign unused_stat  = ^bus.stat_sel;
  assign bus.stat_cnt = '0;
`endif

endmodule
